// File: rtl/axi_lite_regif_if.sv
// axi_lite_regif_if: AXI4-Lite bus bundle between a master and the register-bank bridge
interface axi_lite_regif_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regif.sv
// axi_lite_regif: AXI4-Lite slave to register-bank bridge; optional AXIL_ADDR_DECODE_EN flags indices >= NUM_REGS as SLVERR
module axi_lite_regif #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axi_lite_regif_if.slave         axi,
  output logic [ADDR_WIDTH-3:0]   reg_waddr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  output logic                    reg_we,
  output logic [ADDR_WIDTH-3:0]   reg_raddr,
  output logic                    reg_re,
  input  logic [DATA_WIDTH-1:0]   reg_rdata
);
  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || RD_LATENCY < 0 || RD_LATENCY > 3 || NUM_REGS < 1) begin : g_bad_param
    $error("axi_lite_regif: illegal parameter combination");
  end
  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic aw_held, w_held, aw_hs, w_hs, ar_hs, rd_done, w_err, r_err;
  logic [1:0] rd_cnt;
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{axi.awaddr[1:0], axi.araddr[1:0]};
`ifdef AXIL_ADDR_DECODE_EN
  assign w_err = 32'(reg_waddr) >= NUM_REGS;
  assign r_err = 32'(reg_raddr) >= NUM_REGS;
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif
  assign axi.awready = wr_state == WR_IDLE && !aw_held;
  assign axi.wready  = wr_state == WR_IDLE && !w_held;
  assign aw_hs       = axi.awvalid && axi.awready;
  assign w_hs        = axi.wvalid && axi.wready;
  assign axi.bvalid  = wr_state != WR_IDLE;
  assign axi.bresp   = {axi.bvalid && w_err, 1'b0};
  assign reg_we      = wr_state == WR_EXEC && !w_err;
  assign axi.arready = rd_state == RD_IDLE;
  assign ar_hs       = axi.arvalid && axi.arready;
  assign rd_done     = rd_state == RD_WAIT && rd_cnt == 2'(RD_LATENCY);
  assign axi.rvalid  = rd_state == RD_RESP;
  assign axi.rresp   = {axi.rvalid && r_err, 1'b0};
  assign reg_re      = rd_state == RD_WAIT && rd_cnt == 2'd0 && !r_err;
  // write next state: execute once both halves are held, then wait for bready
  always_comb begin
    wr_next = wr_state;
    wr_next = wr_state == WR_IDLE ? (((aw_held || aw_hs) && (w_held || w_hs)) ? WR_EXEC : WR_IDLE)
                                  : (axi.bready ? WR_IDLE : WR_RESP);
  end
  // write state, independent AW/W latches and the captured bank-side write fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= WR_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      wr_state  <= wr_next;
      aw_held   <= wr_next == WR_EXEC ? 1'b0 : (aw_held || aw_hs);
      w_held    <= wr_next == WR_EXEC ? 1'b0 : (w_held || w_hs);
      reg_waddr <= aw_hs ? axi.awaddr[ADDR_WIDTH-1:2] : reg_waddr;
      reg_wdata <= w_hs ? axi.wdata : reg_wdata;
      reg_wstrb <= w_hs ? axi.wstrb : reg_wstrb;
    end
  end
  // read next state: wait out the bank latency, then hold the response until rready
  always_comb begin
    rd_next = rd_state;
    rd_next = rd_state == RD_IDLE ? (ar_hs ? RD_WAIT : RD_IDLE)
            : rd_state == RD_WAIT ? (rd_done ? RD_RESP : RD_WAIT)
            : (axi.rready ? RD_IDLE : RD_RESP);
  end
  // read state, latency counter and rdata capture (frozen while rvalid is high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= RD_IDLE;
      rd_cnt    <= 2'd0;
      reg_raddr <= '0;
      axi.rdata <= '0;
    end else begin
      rd_state  <= rd_next;
      rd_cnt    <= rd_state == RD_WAIT ? rd_cnt + 2'd1 : 2'd0;
      reg_raddr <= ar_hs ? axi.araddr[ADDR_WIDTH-1:2] : reg_raddr;
      axi.rdata <= rd_done ? (r_err ? '0 : reg_rdata) : axi.rdata;
    end
  end
endmodule

// File: tb/tb_axi_lite_regif.sv
// tb_axi_lite_regif: directed bench for axi_lite_regif with a 2-cycle-latency register bank model
module tb_axi_lite_regif;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  axi_lite_regif_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();
  logic [5:0]  reg_waddr, reg_raddr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;
  logic        reg_we, reg_re;
  axi_lite_regif #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .RD_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .axi(axi),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_we(reg_we),
    .reg_raddr(reg_raddr), .reg_re(reg_re), .reg_rdata(reg_rdata)
  );
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] p1, p2;
  int we_cnt = 0;
  int re_cnt = 0;
  int checks = 0;
  int errors = 0;
  int c_we, c_re;
  assign reg_rdata = p2;
  // bank model: byte-strobed writes, reads return old contents two cycles after reg_re
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) if (reg_we && reg_wstrb[b]) mem[reg_waddr][8*b +: 8] <= reg_wdata[8*b +: 8];
    p1 <= reg_re ? mem[reg_raddr] : 32'hBAD0_0BAD;
    p2 <= p1;
    we_cnt <= we_cnt + int'(reg_we);
    re_cnt <= re_cnt + int'(reg_re);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #12;
    checks++; if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", {axi.awready, axi.wready, axi.arready}); end
    checks++; if ({axi.bvalid, axi.rvalid, reg_we, reg_re} !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", {axi.bvalid, axi.rvalid, reg_we, reg_re}); end
    checks++; if ({axi.bresp, axi.rresp, axi.rdata, reg_waddr, reg_raddr, reg_wdata, reg_wstrb} !== '0) begin errors++; $display("FAIL reset_data: rdata %h wdata %h waddr %0d raddr %0d want all zero", axi.rdata, reg_wdata, reg_waddr, reg_raddr); end
    @(negedge clk) rst_n = 1'b1;
    tick;
  endtask
  task automatic test_write_gap;
    c_we = we_cnt;
    axi.awaddr = 8'h08; axi.awvalid = 1'b1; axi.bready = 1'b1;
    tick; axi.awvalid = 1'b0;
    checks++; if ({axi.awready, axi.wready, reg_we} !== 3'b010) begin errors++; $display("FAIL gap_aw_latched: awready/wready/we %b want 010", {axi.awready, axi.wready, reg_we}); end
    tick; tick;
    axi.wdata = 32'hA5A5_1234; axi.wstrb = 4'b0011; axi.wvalid = 1'b1;
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL gap_early_we: got %b want 0", reg_we); end
    tick; axi.wvalid = 1'b0;
    checks++; if (reg_we !== 1'b1 || reg_waddr !== 6'd2 || reg_wstrb !== 4'b0011 || reg_wdata !== 32'hA5A5_1234) begin errors++; $display("FAIL gap_we: we %b waddr %0d strb %b data %h want 1 2 0011 a5a51234", reg_we, reg_waddr, reg_wstrb, reg_wdata); end
    checks++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin errors++; $display("FAIL gap_b: bvalid %b bresp %b want 1 00", axi.bvalid, axi.bresp); end
    checks++; if ({axi.awready, axi.wready} !== 2'b00) begin errors++; $display("FAIL gap_ready_exec: got %b want 00", {axi.awready, axi.wready}); end
    tick;
    checks++; if ({axi.bvalid, reg_we, axi.awready, axi.wready} !== 4'b0011) begin errors++; $display("FAIL gap_after_b: bvalid/we/awready/wready %b want 0011", {axi.bvalid, reg_we, axi.awready, axi.wready}); end
    checks++; if (we_cnt - c_we !== 1 || mem[2] !== 32'h0000_1234) begin errors++; $display("FAIL gap_count: pulses %0d mem %h want 1 00001234", we_cnt - c_we, mem[2]); end
  endtask
  task automatic test_w_first_and_same_cycle;
    c_we = we_cnt;
    axi.bready = 1'b0; axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    tick; axi.wvalid = 1'b0;
    checks++; if ({axi.awready, axi.wready} !== 2'b10) begin errors++; $display("FAIL wfirst_latched: awready/wready %b want 10", {axi.awready, axi.wready}); end
    tick;
    axi.awaddr = 8'h0C; axi.awvalid = 1'b1;
    tick; axi.awvalid = 1'b0;
    checks++; if (reg_we !== 1'b1 || reg_waddr !== 6'd3 || axi.bvalid !== 1'b1) begin errors++; $display("FAIL wfirst_we: we %b waddr %0d bvalid %b want 1 3 1", reg_we, reg_waddr, axi.bvalid); end
    tick; tick;
    checks++; if ({axi.bvalid, reg_we, axi.awready, axi.wready} !== 4'b1000) begin errors++; $display("FAIL wfirst_stall: bvalid/we/awready/wready %b want 1000", {axi.bvalid, reg_we, axi.awready, axi.wready}); end
    axi.bready = 1'b1;
    tick;
    checks++; if ({axi.bvalid, axi.awready, axi.wready} !== 3'b011) begin errors++; $display("FAIL wfirst_release: bvalid/awready/wready %b want 011", {axi.bvalid, axi.awready, axi.wready}); end
    axi.awaddr = 8'h14; axi.wdata = 32'h1111_1111; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    tick; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checks++; if (reg_we !== 1'b1 || reg_waddr !== 6'd5 || axi.bvalid !== 1'b1) begin errors++; $display("FAIL same_we: we %b waddr %0d bvalid %b want 1 5 1", reg_we, reg_waddr, axi.bvalid); end
    tick;
    checks++; if (we_cnt - c_we !== 2 || mem[3] !== 32'hDEAD_BEEF || mem[5] !== 32'h1111_1111) begin errors++; $display("FAIL same_count: pulses %0d mem3 %h mem5 %h want 2 deadbeef 11111111", we_cnt - c_we, mem[3], mem[5]); end
  endtask
  task automatic test_read_latency;
    c_re = re_cnt;
    axi.rready = 1'b0; axi.araddr = 8'h0C; axi.arvalid = 1'b1;
    checks++; if (axi.arready !== 1'b1) begin errors++; $display("FAIL rd_arready_idle: got %b want 1", axi.arready); end
    tick; axi.arvalid = 1'b0;
    checks++; if (reg_re !== 1'b1 || reg_raddr !== 6'd3 || axi.arready !== 1'b0 || axi.rvalid !== 1'b0) begin errors++; $display("FAIL rd_re: re %b raddr %0d arready %b rvalid %b want 1 3 0 0", reg_re, reg_raddr, axi.arready, axi.rvalid); end
    tick;
    checks++; if ({reg_re, axi.rvalid} !== 2'b00) begin errors++; $display("FAIL rd_n2: re/rvalid %b want 00", {reg_re, axi.rvalid}); end
    tick;
    checks++; if (axi.rvalid !== 1'b0) begin errors++; $display("FAIL rd_n3: rvalid %b want 0", axi.rvalid); end
    tick;
    checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hDEAD_BEEF || axi.rresp !== 2'b00) begin errors++; $display("FAIL rd_n4: rvalid %b rdata %h rresp %b want 1 deadbeef 00", axi.rvalid, axi.rdata, axi.rresp); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'hDEAD_BEEF || axi.arready !== 1'b0) begin errors++; $display("FAIL rd_stall%0d: rvalid %b rdata %h arready %b want 1 deadbeef 0", i, axi.rvalid, axi.rdata, axi.arready); end
    end
    axi.rready = 1'b1;
    tick;
    checks++; if ({axi.rvalid, axi.arready} !== 2'b01 || re_cnt - c_re !== 1) begin errors++; $display("FAIL rd_release: rvalid/arready %b pulses %0d want 01 1", {axi.rvalid, axi.arready}, re_cnt - c_re); end
  endtask
  task automatic test_concurrent;
    axi.awaddr = 8'h14; axi.wdata = 32'h2222_2222; axi.wstrb = 4'hF; axi.araddr = 8'h14;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1; axi.bready = 1'b1; axi.rready = 1'b1;
    tick; axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    checks++; if ({reg_we, reg_re} !== 2'b11 || reg_waddr !== 6'd5 || reg_raddr !== 6'd5) begin errors++; $display("FAIL conc_strobes: we/re %b waddr %0d raddr %0d want 11 5 5", {reg_we, reg_re}, reg_waddr, reg_raddr); end
    checks++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin errors++; $display("FAIL conc_b: bvalid %b bresp %b want 1 00", axi.bvalid, axi.bresp); end
    tick;
    checks++; if ({axi.bvalid, axi.awready, axi.arready} !== 3'b010) begin errors++; $display("FAIL conc_mid: bvalid/awready/arready %b want 010", {axi.bvalid, axi.awready, axi.arready}); end
    tick; tick;
    checks++; if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h1111_1111 || axi.rresp !== 2'b00) begin errors++; $display("FAIL conc_r: rvalid %b rdata %h rresp %b want 1 11111111 00", axi.rvalid, axi.rdata, axi.rresp); end
    tick;
    checks++; if (axi.rvalid !== 1'b0 || mem[5] !== 32'h2222_2222) begin errors++; $display("FAIL conc_end: rvalid %b mem5 %h want 0 22222222", axi.rvalid, mem[5]); end
  endtask
  task automatic test_high_index_zero_strobe;
    axi.awaddr = 8'h40; axi.wdata = 32'hFFFF_FFFF; axi.wstrb = 4'h0; axi.araddr = 8'h43;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    tick; axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    checks++; if (reg_we !== 1'b1 || reg_waddr !== 6'd16 || reg_wstrb !== 4'h0 || axi.bresp !== 2'b00) begin errors++; $display("FAIL hi_write: we %b waddr %0d strb %b bresp %b want 1 16 0000 00", reg_we, reg_waddr, reg_wstrb, axi.bresp); end
    checks++; if (reg_re !== 1'b1 || reg_raddr !== 6'd16) begin errors++; $display("FAIL hi_read: re %b raddr %0d want 1 16", reg_re, reg_raddr); end
    tick; tick; tick;
    checks++; if (axi.rvalid !== 1'b1 || axi.rresp !== 2'b00 || axi.rdata !== 32'h0) begin errors++; $display("FAIL hi_resp: rvalid %b rresp %b rdata %h want 1 00 0", axi.rvalid, axi.rresp, axi.rdata); end
    tick;
  endtask
  task automatic test_reset_mid;
    axi.bready = 1'b0; axi.rready = 1'b0;
    axi.awaddr = 8'h04; axi.wdata = 32'h5555_5555; axi.wstrb = 4'hF; axi.araddr = 8'h08;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    tick; axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    tick; tick; tick;
    checks++; if ({axi.bvalid, axi.rvalid} !== 2'b11 || axi.rdata !== 32'h0000_1234) begin errors++; $display("FAIL rst_pre: bvalid/rvalid %b rdata %h want 11 00001234", {axi.bvalid, axi.rvalid}, axi.rdata); end
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
    c_we = we_cnt; c_re = re_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready} !== 5'b00111 || axi.rdata !== 32'h0) begin errors++; $display("FAIL rst_async: b/r valid, aw/w/ar ready %b rdata %h want 00111 0", {axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready}, axi.rdata); end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    checks++; if (we_cnt !== c_we || re_cnt !== c_re || {axi.bvalid, axi.rvalid} !== 2'b00) begin errors++; $display("FAIL rst_no_strobe: we %0d re %0d valids %b want %0d %0d 00", we_cnt, re_cnt, {axi.bvalid, axi.rvalid}, c_we, c_re); end
  endtask
  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    test_reset;
    test_write_gap;
    test_w_first_and_same_cycle;
    test_read_latency;
    test_concurrent;
    test_high_index_zero_strobe;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
